// File: rtl/rc4_key_search_ctrl.sv
// Sequencer for the RC4 brute-force key search.
// Steps a 24-bit candidate key over [KEY_START, KEY_MAX]. For each candidate it runs the
// S-array init, KSA and PRGA/decrypt phases in that order. It owns the single-port S-memory
// and routes the active phase's request onto it.
module rc4_key_search_ctrl #(
  parameter logic [23:0] KEY_START     = 24'h000000,
  parameter logic [23:0] KEY_MAX       = 24'h3FFFFF,
  parameter int unsigned PHASE_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_search,

  output logic        init_commenco,
  output logic        ksa_commenco,
  output logic        prga_commenco,
  input  logic        init_finito,
  input  logic        ksa_finito,
  input  logic        prga_finito,
  input  logic        prga_valid,

  input  logic [7:0]  init_address,
  input  logic [7:0]  init_data,
  input  logic        init_wen,
  input  logic [7:0]  ksa_address,
  input  logic [7:0]  ksa_data,
  input  logic        ksa_wen,
  input  logic [7:0]  prga_address,
  input  logic [7:0]  prga_data,
  input  logic        prga_wen,

  output logic [7:0]  s_address,
  output logic [7:0]  s_data,
  output logic        s_wen,

  output logic [23:0] secret_key,
  output logic        busy,
  output logic        found,
  output logic        failed,
  output logic        timeout_err
);

  typedef enum logic [3:0] {
    StIdle,
    StInitGo,
    StInitWait,
    StKsaGo,
    StKsaWait,
    StPrgaGo,
    StPrgaWait,
    StCheck,
    StNextKey,
    StFound,
    StFail
  } state_e;

  // A zero timeout disables the watchdog entirely.
  localparam logic        TimeoutEn = (PHASE_TIMEOUT != 0);
  localparam logic [31:0] TimerLast = 32'(PHASE_TIMEOUT) - 32'd1;

  state_e      state_q, state_d;
  logic [23:0] key_q, key_d;
  logic        hit_q, hit_d;
  logic [31:0] timer_q, timer_d;
  logic        timeout_err_q, timeout_err_d;
  logic        timer_expired;

  // The WAIT state has run PHASE_TIMEOUT cycles once the counter sits at its last value.
  assign timer_expired = TimeoutEn && (timer_q == TimerLast);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: candidate key, PRGA hit flag, phase timer, timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q         <= KEY_START;
      hit_q         <= 1'b0;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      key_q         <= key_d;
      hit_q         <= hit_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    hit_d         = hit_q;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle, StFound, StFail: begin
        if (start_search) begin
          key_d         = KEY_START;
          hit_d         = 1'b0;
          timeout_err_d = 1'b0;
          state_d       = StInitGo;
        end
      end

      StInitGo: begin
        timer_d = '0;
        state_d = StInitWait;
      end

      StInitWait: begin
        // A finito arriving on the timeout cycle still counts as success.
        if (init_finito) begin
          state_d = StKsaGo;
        end else if (timer_expired) begin
          timeout_err_d = 1'b1;
          state_d       = StFail;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      StKsaGo: begin
        timer_d = '0;
        state_d = StKsaWait;
      end

      StKsaWait: begin
        if (ksa_finito) begin
          state_d = StPrgaGo;
        end else if (timer_expired) begin
          timeout_err_d = 1'b1;
          state_d       = StFail;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      StPrgaGo: begin
        timer_d = '0;
        hit_d   = 1'b0;
        state_d = StPrgaWait;
      end

      StPrgaWait: begin
        if (prga_finito) begin
          hit_d   = prga_valid;
          state_d = StCheck;
        end else if (timer_expired) begin
          timeout_err_d = 1'b1;
          state_d       = StFail;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      StCheck: begin
        if (hit_q) begin
          state_d = StFound;
        end else if (key_q == KEY_MAX) begin
          state_d = StFail;
        end else begin
          state_d = StNextKey;
        end
      end

      StNextKey: begin
        // Cannot wrap: CHECK stops the search at KEY_MAX.
        key_d   = key_q + 24'd1;
        state_d = StInitGo;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: phase start pulses, status, and the S-memory mux, all decoded from state.
  always_comb begin
    init_commenco = 1'b0;
    ksa_commenco  = 1'b0;
    prga_commenco = 1'b0;
    s_address     = 8'h00;
    s_data        = 8'h00;
    s_wen         = 1'b0;
    busy          = 1'b1;
    found         = 1'b0;
    failed        = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StInitGo, StInitWait: begin
        init_commenco = (state_q == StInitGo);
        s_address     = init_address;
        s_data        = init_data;
        s_wen         = init_wen;
      end
      StKsaGo, StKsaWait: begin
        ksa_commenco = (state_q == StKsaGo);
        s_address    = ksa_address;
        s_data       = ksa_data;
        s_wen        = ksa_wen;
      end
      StPrgaGo, StPrgaWait: begin
        prga_commenco = (state_q == StPrgaGo);
        s_address     = prga_address;
        s_data        = prga_data;
        s_wen         = prga_wen;
      end
      StFound: begin
        busy  = 1'b0;
        found = 1'b1;
      end
      StFail: begin
        busy   = 1'b0;
        failed = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign secret_key  = key_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with stub phases that finish 2 cycles after start.
module tb_rc4_key_search_ctrl;

  logic        clk;
  logic        reset;
  logic        start_search;
  logic        init_commenco, ksa_commenco, prga_commenco;
  logic        init_finito, ksa_finito, prga_finito, prga_valid;
  logic [7:0]  init_address, init_data, ksa_address, ksa_data, prga_address, prga_data;
  logic        init_wen, ksa_wen, prga_wen;
  logic [7:0]  s_address, s_data;
  logic        s_wen;
  logic [23:0] secret_key;
  logic        busy, found, failed, timeout_err;

  // Stub controls.
  logic        init_en, ksa_en, prga_en, force_prga;
  logic        valid_en;
  logic [23:0] valid_key;
  logic [1:0]  init_sr, ksa_sr, prga_sr;

  int          n_checks;
  int          n_fail;
  logic [31:0] log_q[$];
  logic [7:0]  addr_lut[4];
  logic [7:0]  data_lut[4];

  rc4_key_search_ctrl #(
    .KEY_START    (24'h000000),
    .KEY_MAX      (24'h000003),
    .PHASE_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_search (start_search),
    .init_commenco(init_commenco),
    .ksa_commenco (ksa_commenco),
    .prga_commenco(prga_commenco),
    .init_finito  (init_finito),
    .ksa_finito   (ksa_finito),
    .prga_finito  (prga_finito),
    .prga_valid   (prga_valid),
    .init_address (init_address),
    .init_data    (init_data),
    .init_wen     (init_wen),
    .ksa_address  (ksa_address),
    .ksa_data     (ksa_data),
    .ksa_wen      (ksa_wen),
    .prga_address (prga_address),
    .prga_data    (prga_data),
    .prga_wen     (prga_wen),
    .s_address    (s_address),
    .s_data       (s_data),
    .s_wen        (s_wen),
    .secret_key   (secret_key),
    .busy         (busy),
    .found        (found),
    .failed       (failed),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub phases: finito is high during the second cycle after commenco.
  always @(posedge clk) begin
    init_sr <= {init_sr[0], init_commenco};
    ksa_sr  <= {ksa_sr[0], ksa_commenco};
    prga_sr <= {prga_sr[0], prga_commenco};
  end

  assign init_finito = init_sr[1] & init_en;
  assign ksa_finito  = ksa_sr[1] & ksa_en;
  assign prga_finito = (prga_sr[1] & prga_en) | force_prga;
  assign prga_valid  = valid_en && (secret_key == valid_key);

  // Record every start pulse as {phase(1..3), key}.
  always @(negedge clk) begin
    if (init_commenco) log_q.push_back({8'd1, secret_key});
    if (ksa_commenco)  log_q.push_back({8'd2, secret_key});
    if (prga_commenco) log_q.push_back({8'd3, secret_key});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_commenco"}, {29'd0, init_commenco, ksa_commenco, prga_commenco}, 32'd0);
    check({tag, "_s_addr"}, {24'd0, s_address}, 32'd0);
    check({tag, "_s_data"}, {24'd0, s_data}, 32'd0);
    check({tag, "_s_wen"}, {31'd0, s_wen}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Compare the recorded start pulses against n attempts of init, ksa, prga per key.
  task automatic check_log(input string tag, input int n);
    logic [31:0] exp;
    logic [31:0] got;
    check({tag, "_len"}, log_q.size(), n);
    for (int i = 0; i < n; i++) begin
      exp = ((32'(i % 3) + 32'd1) << 24) | 32'(i / 3);
      got = (i < log_q.size()) ? log_q[i] : 32'hFFFF_FFFF;
      check({tag, "_entry"}, got, exp);
    end
  endtask

  initial begin
    int          off;
    int          ph;
    logic [2:0]  exp_cm;

    n_checks = 0;
    n_fail   = 0;
    reset        = 1'b1;
    start_search = 1'b0;
    init_en = 1'b1; ksa_en = 1'b1; prga_en = 1'b1; force_prga = 1'b0;
    valid_en = 1'b0; valid_key = 24'd2;
    init_address = 8'h11; init_data = 8'hA1; init_wen = 1'b1;
    ksa_address  = 8'h22; ksa_data  = 8'hA2; ksa_wen  = 1'b1;
    prga_address = 8'h33; prga_data = 8'hA3; prga_wen = 1'b1;
    addr_lut[0] = 8'h11; addr_lut[1] = 8'h22; addr_lut[2] = 8'h33; addr_lut[3] = 8'h00;
    data_lut[0] = 8'hA1; data_lut[1] = 8'hA2; data_lut[2] = 8'hA3; data_lut[3] = 8'h00;

    // Reset state, with every phase requesting a write.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("rst");
    check("rst_key", {8'd0, secret_key}, 32'd0);
    check("rst_status", {29'd0, found, failed, timeout_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle");

    // Key found at 2, with a full cycle-by-cycle arbitration sweep over key 0.
    valid_en = 1'b1;
    log_q.delete();
    start_search = 1'b1;
    @(negedge clk);
    start_search = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      force_prga = (k == 1);  // spurious prga_finito during INIT_WAIT
      ph = (k < 9) ? (k / 3) : 3;
      exp_cm = ((k % 3 == 0) && (k < 9)) ? (3'b100 >> ph) : 3'b000;
      check("arb_addr", {24'd0, s_address}, {24'd0, addr_lut[ph]});
      check("arb_data", {24'd0, s_data}, {24'd0, data_lut[ph]});
      check("arb_wen", {31'd0, s_wen}, (k < 9) ? 32'd1 : 32'd0);
      check("arb_commenco", {29'd0, init_commenco, ksa_commenco, prga_commenco},
            {29'd0, exp_cm});
      check("arb_busy", {31'd0, busy}, 32'd1);
      check("arb_key", {8'd0, secret_key}, 32'd0);
    end
    force_prga = 1'b0;
    @(negedge clk);
    check("next_key_init", {31'd0, init_commenco}, 32'd1);
    check("next_key_val", {8'd0, secret_key}, 32'd1);
    off = 11;
    while (!found && off < 200) begin
      @(negedge clk);
      off++;
    end
    check("found_cycle", off, 32);
    check("found_flag", {31'd0, found}, 32'd1);
    check("found_key", {8'd0, secret_key}, 32'd2);
    check("found_failed", {30'd0, failed, timeout_err}, 32'd0);
    check_idle_outputs("found");
    check_log("found_log", 9);
    repeat (5) @(negedge clk);
    check("found_hold", {7'd0, found, secret_key}, {7'd0, 1'b1, 24'd2});

    // Exhaustion: restart from FOUND, never valid.
    valid_en = 1'b0;
    log_q.delete();
    start_search = 1'b1;
    @(negedge clk);
    start_search = 1'b0;
    check("exh_restart", {6'd0, found, init_commenco, secret_key}, {6'd0, 2'b01, 24'd0});
    off = 0;
    while (!failed && off < 300) begin
      @(negedge clk);
      off++;
    end
    check("exh_cycle", off, 43);
    check("exh_status", {29'd0, found, failed, timeout_err}, 32'b010);
    check("exh_key", {8'd0, secret_key}, 32'd3);
    check_log("exh_log", 12);

    // Timeout: KSA never finishes.
    ksa_en = 1'b0;
    start_search = 1'b1;
    @(negedge clk);
    start_search = 1'b0;
    off = 0;
    while (!ksa_commenco && off < 50) begin
      @(negedge clk);
      off++;
    end
    check("to_ksa_go", {31'd0, ksa_commenco}, 32'd1);
    repeat (16) @(negedge clk);
    check("to_wait_last", {29'd0, busy, failed, timeout_err}, 32'b100);
    check("to_wait_addr", {24'd0, s_address}, 32'h22);
    @(negedge clk);
    check("to_status", {29'd0, found, failed, timeout_err}, 32'b011);
    check_idle_outputs("to_fail");
    repeat (3) @(negedge clk);
    check("to_wen_after", {31'd0, s_wen}, 32'd0);
    ksa_en = 1'b1;

    // Reset during KSA_WAIT of key 1, then restart.
    valid_en = 1'b1;
    start_search = 1'b1;
    @(negedge clk);
    start_search = 1'b0;
    off = 0;
    while (!(ksa_commenco && secret_key == 24'd1) && off < 100) begin
      @(negedge clk);
      off++;
    end
    check("rm_ksa_key1", {31'd0, ksa_commenco}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_outputs("rm");
    check("rm_key", {8'd0, secret_key}, 32'd0);
    check("rm_status", {29'd0, found, failed, timeout_err}, 32'd0);
    repeat (4) @(negedge clk);
    start_search = 1'b1;
    @(negedge clk);
    start_search = 1'b0;
    check("rm_restart", {7'd0, init_commenco, secret_key}, {7'd0, 1'b1, 24'd0});
    off = 0;
    while (!found && off < 200) begin
      @(negedge clk);
      off++;
    end
    check("rm_found_key", {7'd0, found, secret_key}, {7'd0, 1'b1, 24'd2});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
